// File: rtl/spu_sm_expu_ctrl.sv
// Softmax exponent-pass sequencer: holds the PWL exponent unit config, streams a vector through it, sums the results.
// Latency: element accepted at edge t is presented on out_data after edge t+1; 1 element/cycle at full rate.
// Backpressure: out_ready low freezes stage 2, stage 1 holds its element and in_ready drops; nothing is lost or duplicated.
module spu_sm_expu_ctrl #(
  parameter int LEN_W = 10,
  parameter int SUM_W = 18   // keep >= LEN_W+8 so a full-length pass of 255s cannot wrap
) (
  input  logic              core_clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [4:0]        cfg_addr,
  input  logic [15:0]       cfg_wdata,
  output logic              cfg_err,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [SUM_W-1:0]  sum_out,
  output logic              sum_valid,
  output logic [2:0]        sm_state,
  output logic [8:0]        expu_din_q,
  input  logic [7:0]        expu_dout_q,
  output logic [62:0]       expu_bp,
  output logic [127:0]      expu_bias,
  output logic [63:0]       expu_coeff,
  output logic [3:0]        expu_shift
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = '0;

  state_t             state_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   in_cnt_q;
  logic [LEN_W-1:0]   out_cnt_q;
  logic [SUM_W-1:0]   sum_q;
  logic               s1_vld_q;
  logic               out_vld_q;
  logic [7:0]         out_dat_q;
  logic               done_q;
  logic               sum_vld_q;
  logic               cfg_err_q;
  logic               busy_q;

  logic [8:0]         bp_q    [7];
  logic [15:0]        bias_q  [8];
  logic [7:0]         coeff_q [8];
  logic [3:0]         shift_q;

  logic               adv;
  logic               in_acc;
  logic               s1_fire;
  logic               out_hs;
  logic               cfg_bad;
  logic               cfg_ok;
  logic [SUM_W-1:0]   dout_ext_d;

  // Handshake and advance qualifiers for the two-stage pipeline
  assign adv        = !out_vld_q || out_ready;
  assign in_ready   = (state_q == RUN) && (in_cnt_q < len_q) && (!s1_vld_q || adv);
  assign in_acc     = in_valid && in_ready;
  assign s1_fire    = s1_vld_q && adv;
  assign out_hs     = out_vld_q && out_ready;
  assign dout_ext_d = {{(SUM_W-8){1'b0}}, expu_dout_q};

  // Address 7 and 25..31 have no register behind them
  assign cfg_bad = (cfg_addr == 5'd7) || (cfg_addr > 5'd24);
  assign cfg_ok  = cfg_we && !busy_q && !cfg_bad;

  assign out_valid = out_vld_q;
  assign out_data  = out_dat_q;
  assign sum_out   = sum_q;
  assign sum_valid = sum_vld_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign cfg_err   = cfg_err_q;
  assign sm_state  = busy_q ? 3'b001 : 3'b000;

  // Config register file; frozen while a pass is in flight so the EXPU sees a stable table
  always_ff @(posedge core_clk) begin
    if (rst) begin
      for (int k = 0; k < 7; k++) bp_q[k] <= '0;
      for (int k = 0; k < 8; k++) begin
        bias_q[k]  <= '0;
        coeff_q[k] <= '0;
      end
      shift_q   <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && (busy_q || cfg_bad);
      if (cfg_ok) begin
        for (int k = 0; k < 7; k++) begin
          if (cfg_addr == 5'(k)) bp_q[k] <= cfg_wdata[8:0];
        end
        for (int k = 0; k < 8; k++) begin
          if (cfg_addr == 5'(k + 8))  bias_q[k]  <= cfg_wdata;
          if (cfg_addr == 5'(k + 16)) coeff_q[k] <= cfg_wdata[7:0];
        end
        if (cfg_addr == 5'd24) shift_q <= cfg_wdata[3:0];
      end
    end
  end

  // Flatten the config arrays onto the EXPU buses
  always_comb begin
    expu_bp    = '0;
    expu_bias  = '0;
    expu_coeff = '0;
    for (int k = 0; k < 7; k++) expu_bp[9*k +: 9] = bp_q[k];
    for (int k = 0; k < 8; k++) begin
      expu_bias[16*k +: 16] = bias_q[k];
      expu_coeff[8*k +: 8]  = coeff_q[k];
    end
    expu_shift = shift_q;
  end

  // Pass FSM, element counters, pipeline stages and sum accumulator
  always_ff @(posedge core_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      sum_q      <= '0;
      expu_din_q <= '0;
      s1_vld_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      done_q     <= 1'b0;
      sum_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      sum_vld_q <= 1'b0;

      if (in_acc) begin
        expu_din_q <= in_data;
        in_cnt_q   <= in_cnt_q + LEN_ONE;
      end

      // A fresh capture keeps stage 1 full even when its old element moves on
      if (in_acc) begin
        s1_vld_q <= 1'b1;
      end else if (s1_fire) begin
        s1_vld_q <= 1'b0;
      end

      if (s1_fire) begin
        out_dat_q <= expu_dout_q;
        out_vld_q <= 1'b1;
        sum_q     <= sum_q + dout_ext_d;
      end else if (out_hs) begin
        out_vld_q <= 1'b0;
      end

      if (out_hs) out_cnt_q <= out_cnt_q + LEN_ONE;

      case (state_q)
        IDLE: begin
          if (start) begin
            len_q     <= vec_len;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            sum_q     <= '0;
            busy_q    <= 1'b1;
            if (vec_len == LEN_ZERO) begin
              state_q   <= FIN;
              done_q    <= 1'b1;
              sum_vld_q <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          // Leave on the edge that retires the last result
          if (out_hs && ((out_cnt_q + LEN_ONE) == len_q)) begin
            state_q   <= FIN;
            done_q    <= 1'b1;
            sum_vld_q <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
